// File: rtl/pe_flex_pkg.sv
// Shared types and saturation-bound helpers for the flexible-dataflow MAC PE.
// No timing of its own; consumed by pe_flex and pe_mac_sat.
// No flow control; pure declarations.
package pe_flex_pkg;

    typedef enum logic [1:0] {
        MODE_IS = 2'd0,
        MODE_WS = 2'd1,
        MODE_OS = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Action selected for the current cycle after priority resolution.
    typedef struct packed {
        logic cfg;
        logic ld;
        logic dr;
        logic mac;
    } op_t;

    // Bounds are built wide and sliced by the user to PSUM_W+1 bits.
    localparam int BOUND_W = 130;

    function automatic logic [BOUND_W-1:0] sat_hi(input int psum_w, input int sgn);
        logic [BOUND_W-1:0] one;
        one = {{(BOUND_W-1){1'b0}}, 1'b1};
        sat_hi = (sgn != 0) ? (one << (psum_w - 1)) - one : (one << psum_w) - one;
    endfunction

    function automatic logic [BOUND_W-1:0] sat_lo(input int psum_w, input int sgn);
        logic [BOUND_W-1:0] one;
        one = {{(BOUND_W-1){1'b0}}, 1'b1};
        sat_lo = (sgn != 0) ? ~(one << (psum_w - 1)) + one : '0;
    endfunction

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    decode_mode = MODE_WS;
            2'd2:    decode_mode = MODE_OS;
            default: decode_mode = MODE_IS;
        endcase
    endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational a*b+c with signed/unsigned extension and clamp to the psum range.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result is valid whenever operands are.
module pe_mac_sat
    import pe_flex_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int WT_W   = 16,
    parameter int PSUM_W = 32,
    parameter int SIGNED = 1
) (
    input  logic [IN_W-1:0]   a,
    input  logic [WT_W-1:0]   b,
    input  logic [PSUM_W-1:0] c,
    output logic [PSUM_W-1:0] sum,
    output logic              sat
);
    localparam int PROD_W = IN_W + WT_W;
    localparam logic [BOUND_W-1:0] HI_FULL = sat_hi(PSUM_W, SIGNED);
    localparam logic [BOUND_W-1:0] LO_FULL = sat_lo(PSUM_W, SIGNED);
    localparam logic [PSUM_W:0] HI = HI_FULL[PSUM_W:0];
    localparam logic [PSUM_W:0] LO = LO_FULL[PSUM_W:0];
    localparam logic SX = (SIGNED != 0);

    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod;
    logic [PSUM_W:0]   prod_x;
    logic [PSUM_W:0]   c_x;
    logic [PSUM_W:0]   tot;

    // Extending both operands to the product width makes one multiplier
    // correct for both signed and unsigned arithmetic.
    assign a_x    = {{WT_W{SX & a[IN_W-1]}}, a};
    assign b_x    = {{IN_W{SX & b[WT_W-1]}}, b};
    assign prod   = a_x * b_x;
    assign prod_x = {{(PSUM_W + 1 - PROD_W){SX & prod[PROD_W-1]}}, prod};
    assign c_x    = {SX & c[PSUM_W-1], c};
    assign tot    = prod_x + c_x;

    always_comb begin
        sum = tot[PSUM_W-1:0];
        sat = 1'b0;
        if (SX) begin
            if ($signed(tot) > $signed(HI)) begin
                sum = HI[PSUM_W-1:0];
                sat = 1'b1;
            end else if ($signed(tot) < $signed(LO)) begin
                sum = LO[PSUM_W-1:0];
                sat = 1'b1;
            end
        end else if (tot > HI) begin
            sum = HI[PSUM_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/pe_flex.sv
// Systolic MAC cell with run-time IS/WS/OS dataflow, saturation and OS column drain.
// Latency: 1 cycle MAC to psum_out/acc; drain shifts DRAIN_DEPTH values over DRAIN_DEPTH cycles.
// Backpressure: none; process_en/load_en are dropped while draining.
module pe_flex
    import pe_flex_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int WT_W        = 16,
    parameter int PSUM_W      = 32,
    parameter int SIGNED      = 1,
    parameter int DRAIN_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [1:0]        mode,
    input  logic              load_en,
    input  logic              process_en,
    input  logic              drain,
    input  logic [IN_W-1:0]   input_in,
    input  logic [WT_W-1:0]   weight_in,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [IN_W-1:0]   input_out,
    output logic [WT_W-1:0]   weight_out,
    output logic [PSUM_W-1:0] psum_out,
    output logic              psum_valid,
    output logic              sat_flag,
    output logic              busy
);
    localparam int STAT_W = (IN_W > WT_W) ? IN_W : WT_W;
    localparam int CNT_W  = $clog2(DRAIN_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    mode_t             mode_q;
    op_t               op;
    logic [STAT_W-1:0] stat_reg;
    logic [IN_W-1:0]   input_reg;
    logic [WT_W-1:0]   weight_reg;
    logic [PSUM_W-1:0] psum_reg;
    logic [PSUM_W-1:0] acc;
    logic [CNT_W-1:0]  drain_cnt;
    logic              psum_valid_q;
    logic              sat_flag_q;
    logic              busy_q;
    logic [IN_W-1:0]   mac_a;
    logic [WT_W-1:0]   mac_b;
    logic [PSUM_W-1:0] mac_c;
    logic [PSUM_W-1:0] mac_sum;
    logic              mac_sat;
    logic              in_drain;
    logic              drain_last;

    assign in_drain   = (state == ST_DRAIN);
    assign drain_last = in_drain && (drain_cnt == CNT_LAST);

    // Draining locks out every control input; otherwise strict priority.
    always_comb begin
        op = '0;
        if (!in_drain) begin
            if (cfg_load)
                op.cfg = 1'b1;
            else if (load_en)
                op.ld = 1'b1;
            else if (drain && mode_q == MODE_OS && state == ST_ACTIVE)
                op.dr = 1'b1;
            else if (process_en)
                op.mac = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (op.ld || op.mac) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (op.cfg)
                    state_nxt = ST_IDLE;
                else if (op.dr)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  if (drain_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Single shared MAC: the stationary register replaces one operand in IS/WS,
    // and the accumulator replaces psum_in in OS.
    always_comb begin
        mac_a = input_in;
        mac_b = weight_in;
        mac_c = psum_in;
        case (mode_q)
            MODE_IS: mac_a = stat_reg[IN_W-1:0];
            MODE_WS: mac_b = stat_reg[WT_W-1:0];
            MODE_OS: mac_c = acc;
            default: ;
        endcase
    end

    pe_mac_sat #(
        .IN_W   (IN_W),
        .WT_W   (WT_W),
        .PSUM_W (PSUM_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .c   (mac_c),
        .sum (mac_sum),
        .sat (mac_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_IS;
            stat_reg     <= '0;
            input_reg    <= '0;
            weight_reg   <= '0;
            psum_reg     <= '0;
            acc          <= '0;
            drain_cnt    <= '0;
            psum_valid_q <= 1'b0;
            sat_flag_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            psum_valid_q <= 1'b0;
            busy_q       <= (state_nxt != ST_IDLE);
            if (op.cfg) begin
                sat_flag_q <= 1'b0;
                acc        <= '0;
                if (state == ST_IDLE)
                    mode_q <= decode_mode(mode);
            end
            if (op.ld) begin
                case (mode_q)
                    MODE_IS: stat_reg <= STAT_W'(input_in);
                    MODE_WS: stat_reg <= STAT_W'(weight_in);
                    default: ;
                endcase
            end
            if (op.mac) begin
                sat_flag_q <= sat_flag_q | mac_sat;
                case (mode_q)
                    MODE_WS: begin
                        psum_reg     <= mac_sum;
                        input_reg    <= input_in;
                        psum_valid_q <= 1'b1;
                    end
                    MODE_OS: begin
                        acc        <= mac_sum;
                        input_reg  <= input_in;
                        weight_reg <= weight_in;
                    end
                    default: begin
                        psum_reg     <= mac_sum;
                        weight_reg   <= weight_in;
                        psum_valid_q <= 1'b1;
                    end
                endcase
            end
            // First drain cycle emits this PE's accumulator, the rest shift the column.
            if (in_drain) begin
                psum_valid_q <= 1'b1;
                if (drain_cnt == '0) begin
                    psum_reg <= acc;
                    acc      <= '0;
                end else begin
                    psum_reg <= psum_in;
                end
                drain_cnt <= drain_last ? '0 : drain_cnt + CNT_W'(1);
            end
        end
    end

    assign input_out  = (mode_q == MODE_IS) ? stat_reg[IN_W-1:0] : input_reg;
    assign weight_out = (mode_q == MODE_WS) ? stat_reg[WT_W-1:0] : weight_reg;
    assign psum_out   = psum_reg;
    assign psum_valid = psum_valid_q;
    assign sat_flag   = sat_flag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pe_flex.sv
// Scoreboarded bench for pe_flex: stimulus queues expected psum values, a monitor pops on psum_valid.
module tb_pe_flex;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [1:0]  mode;
    logic        load_en;
    logic        process_en;
    logic        drain;
    logic [15:0] input_in;
    logic [15:0] weight_in;
    logic [31:0] psum_in;
    logic [15:0] input_out;
    logic [15:0] weight_out;
    logic [31:0] psum_out;
    logic        psum_valid;
    logic        sat_flag;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    pe_flex dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .mode       (mode),
        .load_en    (load_en),
        .process_en (process_en),
        .drain      (drain),
        .input_in   (input_in),
        .weight_in  (weight_in),
        .psum_in    (psum_in),
        .input_out  (input_out),
        .weight_out (weight_out),
        .psum_out   (psum_out),
        .psum_valid (psum_valid),
        .sat_flag   (sat_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic do_cfg(input logic [1:0] m);
        cfg_load = 1'b1;
        mode     = m;
        step();
        step();
        cfg_load = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && psum_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL psum_unexpected: got %0h, required no valid output", psum_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (psum_out !== exp_v) begin
                    errors++;
                    $display("FAIL psum_stream: got %0h, required %0h", psum_out, exp_v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_load = 1'b0; mode = 2'd0; load_en = 1'b0; process_en = 1'b0;
        drain = 1'b0; input_in = '0; weight_in = '0; psum_in = '0;
        step(); step();
        chk("rst_psum_out", psum_out, 0);
        chk("rst_psum_valid", psum_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_input_out", input_out, 0);
        chk("rst_weight_out", weight_out, 0);
        rst = 1'b0;
        step();

        // IS: stationary input 3, weight -4, psum_in 10 -> -2
        load_en = 1'b1; input_in = 16'd3; step();
        load_en = 1'b0; process_en = 1'b1; weight_in = 16'hFFFC; psum_in = 32'd10;
        exp_q.push_back(32'hFFFF_FFFE);
        step();
        process_en = 1'b0;
        chk("is_input_out", input_out, 16'd3);
        chk("is_weight_out", weight_out, 16'hFFFC);
        chk("is_busy", busy, 1);
        step();
        chk("is_valid_one_cycle", psum_valid, 0);

        // WS: load+process together loads only; next MAC 7*5+0
        do_cfg(2'd1);
        chk("cfg_to_idle_busy", busy, 0);
        load_en = 1'b1; process_en = 1'b1; weight_in = 16'd5; input_in = 16'd9; psum_in = 32'd100;
        step();
        load_en = 1'b0;
        chk("ws_load_no_mac", psum_valid, 0);
        chk("ws_weight_out", weight_out, 16'd5);
        input_in = 16'd7; psum_in = 32'd0;
        exp_q.push_back(32'd35);
        step();
        process_en = 1'b0;
        chk("ws_input_out", input_out, 16'd7);
        step();

        // OS: 4 x (2*3) = 24, drain (with a dropped MAC) then shift 11,12,13
        do_cfg(2'd2);
        process_en = 1'b1; input_in = 16'd2; weight_in = 16'd3;
        repeat (4) step();
        drain = 1'b1; psum_in = 32'd99;
        exp_q.push_back(32'd24); exp_q.push_back(32'd11);
        exp_q.push_back(32'd12); exp_q.push_back(32'd13);
        step();
        drain = 1'b0; process_en = 1'b0;
        chk("os_input_out", input_out, 16'd2);
        chk("os_weight_out", weight_out, 16'd3);
        psum_in = 32'd11;
        step();
        chk("drain_busy", busy, 1);
        for (int v = 11; v <= 13; v++) begin
            psum_in = 32'(v);
            step();
        end
        step();
        chk("drain_done_valid", psum_valid, 0);
        chk("drain_done_busy", busy, 0);

        // Reset in drain cycle 2 of 4; acc was cleared so 1*1 drains as 1
        process_en = 1'b1; input_in = 16'd1; weight_in = 16'd1; step();
        process_en = 1'b0; drain = 1'b1;
        exp_q.push_back(32'd1);
        step();
        drain = 1'b0; psum_in = 32'd77;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_drain_rst_psum_out", psum_out, 0);
        chk("mid_drain_rst_valid", psum_valid, 0);
        chk("mid_drain_rst_busy", busy, 0);
        chk("mid_drain_rst_sat", sat_flag, 0);
        chk("mid_drain_rst_input_out", input_out, 0);
        chk("mid_drain_rst_weight_out", weight_out, 0);
        step();
        rst = 1'b0;
        step();

        // Saturation in IS (mode back to IS after reset)
        load_en = 1'b1; input_in = 16'd16; step();
        load_en = 1'b0; process_en = 1'b1; weight_in = 16'd16; psum_in = 32'h7FFF_FFF0;
        exp_q.push_back(32'h7FFF_FFFF);
        step();
        chk("sat_flag_set", sat_flag, 1);
        weight_in = 16'd1; psum_in = 32'd0;
        exp_q.push_back(32'd16);
        step();
        chk("sat_flag_sticky", sat_flag, 1);
        weight_in = 16'hFFF0; psum_in = 32'h8000_0000;
        exp_q.push_back(32'h8000_0000);
        step();
        process_en = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        chk("is_drain_ignored", psum_valid, 0);

        // OS: (-32768)^2 twice overflows by one -> clamp; cfg in drain ignored
        do_cfg(2'd2);
        chk("cfg_clears_sat", sat_flag, 0);
        process_en = 1'b1; input_in = 16'h8000; weight_in = 16'h8000;
        step(); step();
        process_en = 1'b0;
        chk("os_sat_flag", sat_flag, 1);
        drain = 1'b1;
        exp_q.push_back(32'h7FFF_FFFF); exp_q.push_back(32'd5);
        exp_q.push_back(32'd6); exp_q.push_back(32'd7);
        step();
        drain = 1'b0; psum_in = 32'd5;
        step();
        cfg_load = 1'b1; mode = 2'd2;
        step();
        cfg_load = 1'b0;
        chk("cfg_in_drain_sat", sat_flag, 1);
        chk("cfg_in_drain_busy", busy, 1);
        psum_in = 32'd6; step();
        psum_in = 32'd7; step();
        step();
        cfg_load = 1'b1; mode = 2'd2; step();
        cfg_load = 1'b0;
        chk("cfg_idle_sat_cleared", sat_flag, 0);
        process_en = 1'b1; input_in = 16'd2; weight_in = 16'd5; step();
        process_en = 1'b0; drain = 1'b1;
        exp_q.push_back(32'd10); exp_q.push_back(32'd1);
        exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        step();
        drain = 1'b0; psum_in = 32'd1;
        step();
        for (int v = 1; v <= 3; v++) begin
            psum_in = 32'(v);
            step();
        end
        step(); step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
